// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART with TX/RX FIFOs and sticky overrun/framing flags.
// Define UART_LOOPBACK_EN to add the STATUS bit4 internal loopback.

module uart_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_c,
    output logic [$clog2(DEPTH):0] count_c,
    output logic                   full_c,
    output logic                   empty_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot a simultaneous push lands in, so full+push+pop is legal.
    assign do_pop  = pop && !empty_c;
    assign do_push = push && (!full_c || pop);

    assign count_c = wr_ptr - rd_ptr;
    assign full_c  = (count_c == PW'(DEPTH));
    assign empty_c = (wr_ptr == rd_ptr);
    assign head_c  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

module uart_mmio_fifo #(
    parameter int unsigned CLOCK_FREQ = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        re,
    input  logic        we,
    input  logic [7:0]  wdata,
    output logic [31:0] rdata,
    input  logic        serial_rx,
    output logic        serial_tx
);
    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam int unsigned PW           = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_RXDATA = 2'd1;
    localparam logic [1:0] A_TXDATA = 2'd2;
    localparam logic [1:0] A_COUNT  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Bus decode
    logic status_wr_c;
    logic tx_wr_c;
    logic rx_pop_c;

    // FIFO views
    logic [7:0]    tx_head_c;
    logic [7:0]    rx_head_c;
    logic [PW-1:0] tx_count_c;
    logic [PW-1:0] rx_count_c;
    logic          tx_full_c;
    logic          tx_empty_c;
    logic          rx_full_c;
    logic          rx_empty_c;

    // Transmitter
    state_t        tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shreg;
    logic          tx_line;
    logic          tx_bit_end_c;
    logic          tx_pop_c;

    // Receiver
    state_t        rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shreg;
    logic          rx_wait;
    logic          rx_s1;
    logic          rx_s2;
    logic          rx_prev;
    logic          rx_line_c;
    logic          rx_fall_c;
    logic          rx_bit_end_c;
    logic          rx_stop_sample_c;
    logic          rx_push_c;

    // Status
    logic          overrun;
    logic          frame_err;
    logic          loopback;
    logic          ovr_set_c;
    logic          frame_set_c;
    logic [31:0]   status_c;

    assign status_wr_c = we && (addr == A_STATUS);
    assign tx_wr_c     = we && (addr == A_TXDATA);
    assign rx_pop_c    = re && (addr == A_RXDATA) && !rx_empty_c;

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_wr_c),
        .push_data (wdata),
        .pop       (tx_pop_c),
        .head_c    (tx_head_c),
        .count_c   (tx_count_c),
        .full_c    (tx_full_c),
        .empty_c   (tx_empty_c)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push_c),
        .push_data (rx_shreg),
        .pop       (rx_pop_c),
        .head_c    (rx_head_c),
        .count_c   (rx_count_c),
        .full_c    (rx_full_c),
        .empty_c   (rx_empty_c)
    );

`ifdef UART_LOOPBACK_EN
    always_ff @(posedge clk) begin
        if (rst)              loopback <= 1'b0;
        else if (status_wr_c) loopback <= wdata[4];
    end

    // Loopback steals the line: the receiver hears the transmitter, the pin idles.
    assign rx_line_c = loopback ? tx_line : serial_rx;
    assign serial_tx = tx_line | loopback;
`else
    assign loopback  = 1'b0;
    assign rx_line_c = serial_rx;
    assign serial_tx = tx_line;
`endif

    // Transmitter: pops on IDLE or at the end of STOP so frames abut with no gap.
    assign tx_bit_end_c = (tx_cnt == CW'(CLKS_PER_BIT - 1));
    assign tx_pop_c     = !tx_empty_c &&
                          ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_bit_end_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (!tx_empty_c) begin
                        tx_state <= S_START;
                        tx_cnt   <= '0;
                        tx_shreg <= tx_head_c;
                        tx_line  <= 1'b0;
                    end
                end
                S_START: begin
                    if (tx_bit_end_c) begin
                        tx_state <= S_DATA;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_line  <= tx_shreg[0];
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tx_bit_end_c) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            tx_line  <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shreg <= {1'b0, tx_shreg[7:1]};
                            tx_line  <= tx_shreg[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (tx_bit_end_c) begin
                        tx_cnt <= '0;
                        if (!tx_empty_c) begin
                            tx_state <= S_START;
                            tx_shreg <= tx_head_c;
                            tx_line  <= 1'b0;
                        end else begin
                            tx_state <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_line_c;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall_c        = rx_prev && !rx_s2;
    assign rx_bit_end_c     = (rx_cnt == CW'(CLKS_PER_BIT - 1));
    assign rx_stop_sample_c = (rx_state == S_STOP) && !rx_wait && rx_bit_end_c;
    assign rx_push_c        = rx_stop_sample_c && rx_s2;
    assign frame_set_c      = rx_stop_sample_c && !rx_s2;
    assign ovr_set_c        = rx_push_c && rx_full_c && !rx_pop_c;

    // Receiver: after the half-bit start check every sample lands mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
            rx_wait  <= 1'b0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_fall_c) begin
                        rx_state <= S_START;
                        rx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (rx_cnt == CW'(HALF_BIT - 1)) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_bit_end_c) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_s2, rx_shreg[7:1]};
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    // A low stop bit parks here until the line recovers.
                    if (rx_wait) begin
                        if (rx_s2) begin
                            rx_wait  <= 1'b0;
                            rx_state <= S_IDLE;
                        end
                    end else if (rx_bit_end_c) begin
                        rx_cnt <= '0;
                        if (rx_s2) rx_state <= S_IDLE;
                        else       rx_wait  <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Sticky flags: write-1-to-clear, a same-cycle set takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (status_wr_c && wdata[2]) overrun   <= 1'b0;
            if (status_wr_c && wdata[3]) frame_err <= 1'b0;
            if (ovr_set_c)               overrun   <= 1'b1;
            if (frame_set_c)             frame_err <= 1'b1;
        end
    end

    assign status_c = {27'd0, loopback, frame_err, overrun, !rx_empty_c, !tx_full_c};

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            case (addr)
                A_STATUS: rdata <= status_c;
                A_RXDATA: rdata <= rx_empty_c ? 32'd0 : {24'd0, rx_head_c};
                A_TXDATA: rdata <= 32'd0;
                A_COUNT:  rdata <= {16'd0, 8'(tx_count_c), 8'(rx_count_c)};
                default:  rdata <= 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo at 10 clk/bit, FIFO depth 4, with TX/RX scoreboards.

module tb_uart_mmio_fifo;
    localparam int unsigned CPB = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic        re;
    logic        we;
    logic [7:0]  wdata;
    logic [31:0] rdata;
    logic        serial_rx;
    logic        serial_tx;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] tx_got[$];
    logic       tx_stop_got[$];
    int         tx_start[$];
    logic [7:0] rx_exp[$];
    int         rx_model_cnt = 0;
    logic       mon_en = 1'b0;
    int         mon_t0;
    logic [7:0] mon_b;

    logic [31:0] rd;
    logic [99:0] got_wave;
    logic [99:0] exp_wave;
    logic [9:0]  frame;
    int          lat;
    int          t_wr;
    logic        all_high;
    logic        seen;

    uart_mmio_fifo #(
        .CLOCK_FREQ (1000000),
        .BAUD_RATE  (100000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .re        (re),
        .we        (we),
        .wdata     (wdata),
        .rdata     (rdata),
        .serial_rx (serial_rx),
        .serial_tx (serial_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit (checks passed %0d of %0d)", passes, checks);
        $fatal(1, "watchdog expired");
    end

    // Decodes frames on serial_tx, sampling each bit near its middle.
    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (mon_en && serial_tx === 1'b0) begin
                mon_t0 = cyc;
                repeat (4) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[k] = serial_tx;
                end
                repeat (CPB) @(negedge clk);
                tx_stop_got.push_back(serial_tx);
                tx_got.push_back(mon_b);
                tx_start.push_back(mon_t0);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        d = rdata;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        serial_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            serial_rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        serial_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        serial_rx = 1'b1;
    endtask

    // Scoreboard model of the receive FIFO: accept while room, otherwise drop.
    task automatic rx_expect(input logic [7:0] b);
        if (rx_model_cnt < 4) begin
            rx_exp.push_back(b);
            rx_model_cnt++;
        end
    endtask

    task automatic rx_read_expect(input string tag);
        logic [7:0] e;
        e = rx_exp.pop_front();
        rx_model_cnt--;
        bus_read(2'd1, rd);
        check(tag, rd, {24'd0, e});
    endtask

    initial begin : stim
        rst = 1'b1; addr = 2'd0; re = 1'b0; we = 1'b0; wdata = 8'd0; serial_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rdata", rdata, 32'd0);
        check("reset_serial_tx", {31'd0, serial_tx}, 32'd1);
        bus_read(2'd0, rd);
        check("reset_status", rd, 32'h1);
        bus_read(2'd3, rd);
        check("reset_count", rd, 32'h0);

        // Single TX byte: latency and exact waveform
        bus_write(2'd2, 8'hA5);
        lat = 0;
        for (int i = 1; i <= 3; i++) begin
            if (lat == 0 && serial_tx === 1'b0) lat = i - 1;
            if (lat == 0) @(negedge clk);
        end
        if (lat == 0 && serial_tx === 1'b0) lat = 3;
        check("tx_start_latency_ok", {31'd0, (lat >= 1 && lat <= 2)}, 32'd1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 100; i++) begin
            exp_wave[i] = frame[i / 10];
            got_wave[i] = serial_tx;
            @(negedge clk);
        end
        checks++;
        assert (got_wave === exp_wave) begin
            passes++;
        end else begin
            $error("FAIL tx_wave_a5: observed %h expected %h", got_wave, exp_wave);
        end
        bus_read(2'd0, rd);
        check("tx_done_status", rd, 32'h1);
        bus_read(2'd3, rd);
        check("tx_done_count_tx", {24'd0, rd[15:8]}, 32'd0);

        // Back-to-back writes overflow the 4-deep TX FIFO by one
        mon_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            addr = 2'd2; wdata = 8'(i); we = 1'b1;
            if (i <= 5) tx_exp.push_back(8'(i));
        end
        @(negedge clk);
        we = 1'b0;
        bus_read(2'd0, rd);
        check("tx_fifo_full_status", rd, 32'h0);
        for (int i = 0; i < 800 && tx_got.size() < 5; i++) @(negedge clk);
        repeat (150) @(negedge clk);
        mon_en = 1'b0;
        check("tx_frame_count", tx_got.size(), 32'd5);
        while (tx_got.size() > 0 && tx_exp.size() > 0) begin
            check("tx_frame_byte", {24'd0, tx_got.pop_front()}, {24'd0, tx_exp.pop_front()});
            check("tx_frame_stop", {31'd0, tx_stop_got.pop_front()}, 32'd1);
        end
        for (int i = 1; i < tx_start.size(); i++)
            check("tx_frame_spacing", tx_start[i] - tx_start[i-1], 32'd100);
        tx_start.delete();

        // Single RX byte, then empty-read behaviour
        rx_expect(8'h3C);
        send_rx(8'h3C, 1'b1);
        bus_read(2'd0, rd);
        check("rx_valid_status", rd, 32'h3);
        rx_read_expect("rx_byte_3c");
        bus_read(2'd1, rd);
        check("rx_empty_read", rd, 32'd0);
        bus_read(2'd0, rd);
        check("rx_empty_status", rd, 32'h1);

        // Short glitch must be rejected
        @(negedge clk);
        serial_rx = 1'b0;
        repeat (4) @(negedge clk);
        serial_rx = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(2'd3, rd);
        check("glitch_count", rd, 32'd0);
        bus_read(2'd0, rd);
        check("glitch_status", rd, 32'h1);

        // Framing error: sticky, write-0 has no effect, write-1 clears
        send_rx(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        bus_read(2'd0, rd);
        check("frame_err_set", rd, 32'h9);
        bus_read(2'd3, rd);
        check("frame_err_count", {24'd0, rd[7:0]}, 32'd0);
        bus_write(2'd0, 8'h00);
        bus_read(2'd0, rd);
        check("frame_err_write0", rd, 32'h9);
        bus_write(2'd0, 8'h08);
        bus_read(2'd0, rd);
        check("frame_err_cleared", rd, 32'h1);

        // Overrun: five bytes into four slots
        for (int i = 0; i < 5; i++) begin
            rx_expect(8'h10 + 8'(i));
            send_rx(8'h10 + 8'(i), 1'b1);
        end
        repeat (10) @(negedge clk);
        bus_read(2'd0, rd);
        check("overrun_status", rd, 32'h7);
        bus_read(2'd3, rd);
        check("overrun_count", rd, 32'h4);
        while (rx_exp.size() > 0) rx_read_expect("overrun_byte");
        bus_read(2'd0, rd);
        check("overrun_sticky", rd, 32'h5);
        bus_write(2'd0, 8'h04);
        bus_read(2'd0, rd);
        check("overrun_cleared", rd, 32'h1);

        // Reset in the middle of a TX frame
        bus_write(2'd2, 8'h00);
        bus_write(2'd2, 8'h00);
        repeat (40) @(negedge clk);
        check("midframe_line_low", {31'd0, serial_tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_reset_tx", {31'd0, serial_tx}, 32'd1);
        rst = 1'b0;
        check("midframe_reset_rdata", rdata, 32'd0);
        bus_read(2'd3, rd);
        check("midframe_reset_count", rd, 32'd0);
        bus_read(2'd0, rd);
        check("midframe_reset_status", rd, 32'h1);
        all_high = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (serial_tx !== 1'b1) all_high = 1'b0;
            @(negedge clk);
        end
        check("midframe_reset_idle", {31'd0, all_high}, 32'd1);

`ifdef UART_LOOPBACK_EN
        bus_write(2'd0, 8'h10);
        bus_read(2'd0, rd);
        check("loopback_status", rd, 32'h11);
        rx_expect(8'h5A);
        bus_write(2'd2, 8'h5A);
        t_wr = cyc;
        all_high = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 150 && !seen; i++) begin
            if (serial_tx !== 1'b1) all_high = 1'b0;
            bus_read(2'd0, rd);
            if (rd[1]) seen = 1'b1;
        end
        check("loopback_rx_valid", {31'd0, seen}, 32'd1);
        check("loopback_latency_ok", {31'd0, (cyc - t_wr) >= 100}, 32'd1);
        check("loopback_line_high", {31'd0, all_high}, 32'd1);
        rx_read_expect("loopback_byte");
        bus_write(2'd0, 8'h00);
        bus_read(2'd0, rd);
        check("loopback_off", rd, 32'h1);
`else
        bus_write(2'd0, 8'h10);
        bus_read(2'd0, rd);
        check("loopback_absent", rd, 32'h1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
